bus_terminal_fifo: RTL and testbench

- Per-terminal interface FIFO that sits on one port of the N-driver bus generator/arbiter.
- Buffers packets written by the local host into a TX queue and presents them to the bus through pndng/D_pop/pop.
- Captures packets the bus delivers through push/D_push into an RX queue that the host drains.
- One instance per bus port; the bus connects to this block exactly as it connects to a driver-side FIFO.

---
 rtl/bus_terminal_fifo.sv | 136 +++++++++++++
 tb/tb_bus_terminal_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_terminal_fifo.sv
// Per-terminal bus FIFO: host TX queue presented to the bus, bus RX queue drained by the host.
// Optional destination filtering on received packets is enabled by defining ID_CHECK_EN.
module bus_terminal_fifo #(
    parameter int unsigned pckg_sz  = 16,
    parameter int unsigned depth    = 8,
    parameter logic [7:0]  term_id  = 8'd0,
    parameter logic [7:0]  bcast_id = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tx_wr,
    input  logic [pckg_sz-1:0]       tx_data,
    output logic                     tx_full,
    output logic [$clog2(depth):0]   tx_count,
    input  logic                     rx_rd,
    output logic [pckg_sz-1:0]       rx_data,
    output logic                     rx_empty,
    output logic [$clog2(depth):0]   rx_count,
    output logic                     pndng,
    output logic [pckg_sz-1:0]       D_pop,
    input  logic                     pop,
    input  logic                     push,
    input  logic [pckg_sz-1:0]       D_push,
    output logic [7:0]               ovf_cnt,
    output logic                     underflow_err
);

    localparam int unsigned AW   = $clog2(depth);
    localparam logic [AW:0] FULL = (AW + 1)'(depth);

    logic [pckg_sz-1:0] tx_mem [depth];
    logic [pckg_sz-1:0] rx_mem [depth];

    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [AW:0]   tx_cnt, rx_cnt;
    logic          armed;

    logic tx_wr_g, pop_g, push_g, rx_rd_g;
    logic tx_pop_ok, tx_wr_ok, tx_drop;
    logic rx_rd_ok, rx_push_ok, rx_drop, rx_id_ok;
    logic underflow_set;
    logic [8:0] ovf_sum;
    logic [7:0] ovf_next;

    // All strobes are masked on the first edge after reset is released.
    assign tx_wr_g = tx_wr & armed;
    assign pop_g   = pop   & armed;
    assign push_g  = push  & armed;
    assign rx_rd_g = rx_rd & armed;

`ifdef ID_CHECK_EN
    assign rx_id_ok = (D_push[pckg_sz-1 -: 8] == term_id) ||
                      (D_push[pckg_sz-1 -: 8] == bcast_id);
`else
    // Every destination is accepted; the ID parameters have no effect here.
    assign rx_id_ok = 1'b1 | (term_id == bcast_id);
`endif

    // A full queue still accepts a write when its head leaves on the same edge.
    assign tx_pop_ok  = pop_g & (tx_cnt != '0);
    assign tx_wr_ok   = tx_wr_g & ((tx_cnt != FULL) | tx_pop_ok);
    assign tx_drop    = tx_wr_g & ~tx_wr_ok;

    assign rx_rd_ok   = rx_rd_g & (rx_cnt != '0);
    assign rx_push_ok = push_g & rx_id_ok & ((rx_cnt != FULL) | rx_rd_ok);
    assign rx_drop    = push_g & ~rx_push_ok;

    assign underflow_set = (pop_g & (tx_cnt == '0)) | (rx_rd_g & (rx_cnt == '0));

    assign ovf_sum  = {1'b0, ovf_cnt} + {8'd0, tx_drop} + {8'd0, rx_drop};
    assign ovf_next = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];

    always_ff @(posedge clk) begin
        if (tx_wr_ok) begin
            tx_mem[tx_wr_ptr] <= tx_data;
        end
        if (rx_push_ok) begin
            rx_mem[rx_wr_ptr] <= D_push;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed         <= 1'b0;
            tx_wr_ptr     <= '0;
            tx_rd_ptr     <= '0;
            tx_cnt        <= '0;
            rx_wr_ptr     <= '0;
            rx_rd_ptr     <= '0;
            rx_cnt        <= '0;
            ovf_cnt       <= '0;
            underflow_err <= 1'b0;
        end else begin
            armed <= 1'b1;

            if (tx_wr_ok) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop_ok) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            case ({tx_wr_ok, tx_pop_ok})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase

            if (rx_push_ok) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (rx_rd_ok) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            case ({rx_push_ok, rx_rd_ok})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase

            ovf_cnt <= ovf_next;
            if (underflow_set) begin
                underflow_err <= 1'b1;
            end
        end
    end

    assign tx_full  = (tx_cnt == FULL);
    assign tx_count = tx_cnt;
    assign pndng    = (tx_cnt != '0);
    assign D_pop    = pndng ? tx_mem[tx_rd_ptr] : '0;

    assign rx_empty = (rx_cnt == '0);
    assign rx_count = rx_cnt;
    assign rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr];

endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Directed self-checking bench for bus_terminal_fifo (depth 8, 16-bit packets, term_id 2).
// Builds with or without ID_CHECK_EN; the ID filtering expectations follow the macro.
module tb_bus_terminal_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_wr;
    logic [15:0] tx_data;
    logic        tx_full;
    logic [3:0]  tx_count;
    logic        rx_rd;
    logic [15:0] rx_data;
    logic        rx_empty;
    logic [3:0]  rx_count;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic [7:0]  ovf_cnt;
    logic        underflow_err;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    bus_terminal_fifo #(
        .pckg_sz (16),
        .depth   (8),
        .term_id (8'd2),
        .bcast_id(8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_wr        (tx_wr),
        .tx_data      (tx_data),
        .tx_full      (tx_full),
        .tx_count     (tx_count),
        .rx_rd        (rx_rd),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_count     (rx_count),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .ovf_cnt      (ovf_cnt),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge, then spend the masked first post-reset edge.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic tx_write(input logic [15:0] d);
        tx_wr = 1'b1; tx_data = d;
        tick();
        tx_wr = 1'b0;
    endtask

    task automatic rx_push(input logic [15:0] d);
        push = 1'b1; D_push = d;
        tick();
        push = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tx_wr = 1'b0; tx_data = '0; rx_rd = 1'b0;
        pop = 1'b0; push = 1'b0; D_push = '0;
        repeat (5) tick();
        check("rst_pndng",    32'(pndng), 32'd0);
        check("rst_rx_empty", 32'(rx_empty), 32'd1);
        check("rst_tx_full",  32'(tx_full), 32'd0);
        check("rst_tx_count", 32'(tx_count), 32'd0);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_ovf",      32'(ovf_cnt), 32'd0);
        check("rst_uf",       32'(underflow_err), 32'd0);
        check("rst_D_pop",    32'(D_pop), 32'd0);
        check("rst_rx_data",  32'(rx_data), 32'd0);

        // First edge after release must ignore the write.
        reset = 1'b0;
        tx_write(16'hDEAD);
        check("first_edge_ignored", 32'(tx_count), 32'd0);

        // TX fill, overflow and drain
        for (int i = 1; i <= 8; i++) begin
            tx_write({i[7:0], i[7:0]});
            if (i == 1) check("wr_to_pndng", 32'(pndng), 32'd1);
        end
        check("tx_full_at_8", 32'(tx_full), 32'd1);
        tx_write(16'h0909);
        check("tx_ovf_count", 32'(tx_count), 32'd8);
        check("tx_ovf_cnt",   32'(ovf_cnt), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("drain_D_pop", 32'(D_pop), 32'({i[7:0], i[7:0]}));
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        check("drained_pndng", 32'(pndng), 32'd0);
        check("drained_D_pop", 32'(D_pop), 32'd0);

        // Full queue with simultaneous write and pop
        for (int i = 1; i <= 8; i++) tx_write(16'h1000 + 16'(i));
        tx_wr = 1'b1; tx_data = 16'hAAAA; pop = 1'b1;
        tick();
        tx_wr = 1'b0; pop = 1'b0;
        check("full_wrpop_count", 32'(tx_count), 32'd8);
        check("full_wrpop_ovf",   32'(ovf_cnt), 32'd1);
        for (int i = 2; i <= 8; i++) begin
            check("full_wrpop_seq", 32'(D_pop), 32'h1000 + 32'(i));
            pop = 1'b1;
            tick();
        end
        check("full_wrpop_last", 32'(D_pop), 32'hAAAA);
        tick();
        pop = 1'b0;
        check("full_wrpop_empty", 32'(tx_count), 32'd0);

        // RX overflow, then full push with simultaneous read
        for (int i = 1; i <= 9; i++) begin
            rx_push(16'(i));
            if (i == 1) begin
                check("push_to_rx_empty", 32'(rx_empty), 32'd0);
                check("rx_fwft_head",     32'(rx_data), 32'h0001);
            end
        end
        check("rx_ovf_count", 32'(rx_count), 32'd8);
        check("rx_ovf_cnt",   32'(ovf_cnt), 32'd2);
        push = 1'b1; D_push = 16'h000A; rx_rd = 1'b1;
        tick();
        push = 1'b0; rx_rd = 1'b0;
        check("rx_full_pushrd_count", 32'(rx_count), 32'd8);
        check("rx_full_pushrd_ovf",   32'(ovf_cnt), 32'd2);
        for (int i = 2; i <= 8; i++) begin
            check("rx_read_seq", 32'(rx_data), 32'(i));
            rx_rd = 1'b1;
            tick();
        end
        check("rx_read_last", 32'(rx_data), 32'h000A);
        tick();
        rx_rd = 1'b0;
        check("rx_drained_empty", 32'(rx_empty), 32'd1);
        check("rx_drained_data",  32'(rx_data), 32'd0);
        check("uf_clean_so_far",  32'(underflow_err), 32'd0);

        // Underflow stickiness
        pop = 1'b1; tick(); pop = 1'b0;
        check("uf_pop_empty", 32'(underflow_err), 32'd1);
        tick();
        check("uf_sticky", 32'(underflow_err), 32'd1);
        rx_rd = 1'b1; tick(); rx_rd = 1'b0;
        check("uf_rd_empty_still", 32'(underflow_err), 32'd1);
        do_reset();
        check("uf_cleared", 32'(underflow_err), 32'd0);
        check("ovf_cleared", 32'(ovf_cnt), 32'd0);
        rx_rd = 1'b1; tick(); rx_rd = 1'b0;
        check("uf_rd_empty_only", 32'(underflow_err), 32'd1);
        do_reset();

        // Write and pop together on an empty queue
        tx_wr = 1'b1; tx_data = 16'h5A5A; pop = 1'b1;
        tick();
        tx_wr = 1'b0; pop = 1'b0;
        check("wrpop_empty_count", 32'(tx_count), 32'd1);
        check("wrpop_empty_uf",    32'(underflow_err), 32'd1);
        check("wrpop_empty_D_pop", 32'(D_pop), 32'h5A5A);
        rx_push(16'h0123);
        do_reset();
        check("rst_discard_tx", 32'(tx_count), 32'd0);
        check("rst_discard_rx", 32'(rx_empty), 32'd1);

        // Destination filtering
        rx_push(16'h0255);
        rx_push(16'h0355);
        rx_push(16'hFF55);
        check("id_head", 32'(rx_data), 32'h0255);
`ifdef ID_CHECK_EN
        check("id_count", 32'(rx_count), 32'd2);
        check("id_ovf",   32'(ovf_cnt), 32'd1);
        rx_rd = 1'b1; tick(); rx_rd = 1'b0;
        check("id_second", 32'(rx_data), 32'hFF55);
`else
        check("id_count", 32'(rx_count), 32'd3);
        check("id_ovf",   32'(ovf_cnt), 32'd0);
        rx_rd = 1'b1; tick(); rx_rd = 1'b0;
        check("id_second", 32'(rx_data), 32'h0355);
`endif
        do_reset();

        // ovf_cnt saturation with simultaneous TX and RX drops
        for (int i = 0; i < 8; i++) begin
            tx_wr = 1'b1; tx_data = 16'(i); push = 1'b1; D_push = 16'(i);
            tick();
        end
        repeat (127) tick();
        check("ovf_254", 32'(ovf_cnt), 32'd254);
        tick();
        check("ovf_sat_255", 32'(ovf_cnt), 32'd255);
        tick();
        check("ovf_hold_255", 32'(ovf_cnt), 32'd255);
        tx_wr = 1'b0; push = 1'b0;
        check("sat_tx_count", 32'(tx_count), 32'd8);
        check("sat_rx_count", 32'(rx_count), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
